// File: rtl/sys_cmd_pkg.sv
// Shared types and constants for the system command controller.
package sys_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_REQ, S_RD_PUSH, S_BRD_ADDR,
    S_BRD_CNT, S_OPA, S_OPB, S_ALU_FUN, S_ALU_WAIT, S_ALU_PUSH
  } state_t;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] CMD_BRD     = 8'hEE;

  // States that are waiting for the next frame of a command (subject to gap timeout)
  function automatic logic is_frame_wait(input state_t s);
    return s inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB,
                     S_ALU_FUN, S_BRD_ADDR, S_BRD_CNT};
  endfunction

endpackage

// File: rtl/sys_cmd_txser.sv
// Captures a word and pushes it to the TX FIFO one DATA_W byte at a time, LSB first.
module sys_cmd_txser #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              en,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_vld,
  output logic              last
);
  localparam int NB = WORD_W / DATA_W;

  logic [NB-1:0][DATA_W-1:0] hold;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      hold <= '0;
    else if (load) hold <= word;
  end

  assign tx_vld = en && !fifo_full;

  generate
    if (NB == 1) begin : g_one
      assign tx_data = hold[0];
      assign last    = tx_vld;
    end else begin : g_multi
      localparam int IDX_W = $clog2(NB);
      localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
      logic [IDX_W-1:0] idx;

      // Index only advances on an accepted push, so FIFO_FULL never drops or repeats a byte
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)        idx <= '0;
        else if (load)   idx <= '0;
        else if (tx_vld) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      assign tx_data = hold[idx];
      assign last    = tx_vld && (idx == IDX_LAST);
    end
  endgenerate

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Frame decoder: turns UART RX command frames into register, burst-read and ALU operations.
module sys_cmd_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int ALU_OUT_W   = 16,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [DATA_W-1:0]    RdData,
  input  logic                 RdData_Valid,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 OUT_Valid,
  input  logic                 FIFO_FULL,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic [ADDR_W-1:0]    Address,
  output logic                 WrEn,
  output logic [DATA_W-1:0]    WrData,
  output logic                 RdEn,
  output logic [FUN_W-1:0]     ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLK_EN,
  output logic                 clk_div_en,
  output logic                 cmd_err,
  output logic                 busy
);
  localparam int GAP_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT_CYC - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   rem, rem_nx;
  logic [FUN_W-1:0]    fun_q, fun_nx;
  logic [GAP_W-1:0]    gap;
  logic                err_nx, timeout;
  logic                rd_load, alu_load, rd_push, alu_push;
  logic [DATA_W-1:0]   rd_tx, alu_tx;
  logic                rd_vld, alu_vld, rd_last, alu_last;

  sys_cmd_txser #(.DATA_W(DATA_W), .WORD_W(DATA_W)) u_rd_ser (
    .CLK(CLK), .RST(RST), .load(rd_load), .word(RdData), .en(rd_push),
    .fifo_full(FIFO_FULL), .tx_data(rd_tx), .tx_vld(rd_vld), .last(rd_last)
  );

  sys_cmd_txser #(.DATA_W(DATA_W), .WORD_W(ALU_OUT_W)) u_alu_ser (
    .CLK(CLK), .RST(RST), .load(alu_load), .word(ALU_OUT), .en(alu_push),
    .fifo_full(FIFO_FULL), .tx_data(alu_tx), .tx_vld(alu_vld), .last(alu_last)
  );

  assign rd_push    = (state == S_RD_PUSH);
  assign alu_push   = (state == S_ALU_PUSH);
  assign TX_D_VLD   = rd_vld | alu_vld;
  assign busy       = (state != S_IDLE);
  assign clk_div_en = 1'b1;
  assign timeout    = (TIMEOUT_CYC > 0) && is_frame_wait(state) && !RX_D_VLD && (gap == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      Address <= '0;
      rem     <= '0;
      fun_q   <= '0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_nx;
      Address <= addr_nx;
      rem     <= rem_nx;
      fun_q   <= fun_nx;
      cmd_err <= err_nx;
    end
  end

  // Frame-gap down-counter, reloaded on each frame and on every state change
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                 gap <= '0;
    else if (RX_D_VLD || state_nx != state)   gap <= GAP_LOAD;
    else if (gap != '0)                       gap <= gap - 1'b1;
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = Address;
    rem_nx    = rem;
    fun_nx    = fun_q;
    err_nx    = 1'b0;
    WrEn      = 1'b0;
    WrData    = '0;
    RdEn      = 1'b0;
    ALU_FUN   = '0;
    ALU_EN    = 1'b0;
    CLK_EN    = 1'b0;
    TX_P_DATA = '0;
    rd_load   = 1'b0;
    alu_load  = 1'b0;
    case (state)
      S_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          DATA_W'(CMD_WR):      state_nx = S_WR_ADDR;
          DATA_W'(CMD_RD):      state_nx = S_RD_ADDR;
          DATA_W'(CMD_BRD):     state_nx = S_BRD_ADDR;
          DATA_W'(CMD_ALU_NOP): state_nx = S_ALU_FUN;
          DATA_W'(CMD_ALU_OP): begin
            state_nx = S_OPA;
            addr_nx  = ADDR_W'(OPA_ADDR);
          end
          default:              err_nx = 1'b1;
        endcase
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        addr_nx  = RX_P_DATA[ADDR_W-1:0];
        state_nx = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        WrEn     = 1'b1;
        WrData   = RX_P_DATA;
        state_nx = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        addr_nx  = RX_P_DATA[ADDR_W-1:0];
        rem_nx   = DATA_W'(1);
        state_nx = S_RD_REQ;
      end
      S_RD_REQ: begin
        RdEn = !RdData_Valid;
        if (RdData_Valid) begin
          rd_load  = 1'b1;
          state_nx = S_RD_PUSH;
        end
      end
      S_RD_PUSH: begin
        TX_P_DATA = rd_tx;
        if (rd_last) begin
          rem_nx = rem - 1'b1;
          if (rem_nx != '0) begin
            addr_nx  = Address + 1'b1;
            state_nx = S_RD_REQ;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_BRD_ADDR: if (RX_D_VLD) begin
        addr_nx  = RX_P_DATA[ADDR_W-1:0];
        state_nx = S_BRD_CNT;
      end
      S_BRD_CNT: if (RX_D_VLD) begin
        rem_nx   = RX_P_DATA;
        state_nx = (RX_P_DATA == '0) ? S_IDLE : S_RD_REQ;
      end
      S_OPA: if (RX_D_VLD) begin
        WrEn     = 1'b1;
        WrData   = RX_P_DATA;
        addr_nx  = ADDR_W'(OPB_ADDR);
        state_nx = S_OPB;
      end
      S_OPB: if (RX_D_VLD) begin
        WrEn     = 1'b1;
        WrData   = RX_P_DATA;
        state_nx = S_ALU_FUN;
      end
      S_ALU_FUN: begin
        CLK_EN = 1'b1;
        if (RX_D_VLD) begin
          ALU_EN   = 1'b1;
          ALU_FUN  = RX_P_DATA[FUN_W-1:0];
          fun_nx   = RX_P_DATA[FUN_W-1:0];
          state_nx = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        ALU_FUN = fun_q;
        if (OUT_Valid) begin
          alu_load = 1'b1;
          state_nx = S_ALU_PUSH;
        end else begin
          CLK_EN = 1'b1;
          ALU_EN = 1'b1;
        end
      end
      S_ALU_PUSH: begin
        TX_P_DATA = alu_tx;
        if (alu_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Timeout only fires on a cycle with no frame, so no write or ALU strobe is issued
    if (timeout) begin
      state_nx = S_IDLE;
      err_nx   = 1'b1;
    end
  end

endmodule
